// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // Requester ids: the CPU gets 0, the program loader gets 1.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational two-way round-robin pick: a tie goes to whoever did not win last.
module rr_picker
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic winner
);

    // A single request wins outright; a tie flips away from last_grant.
    always_comb begin
        valid  = req0 | req1;
        winner = REQ_CPU;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else if (req1) begin
            winner = REQ_LDR;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU and a program loader onto one synchronous-read memory port.
// Each access takes two cycles: ACCESS issues the command, RESP returns data.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic pick_valid, pick_winner;
    logic keep, ld, ld_id;

    rr_picker u_rr (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // The current winner keeps the port when it holds both lock and req.
    assign keep = (win_q == REQ_LDR) ? (lock1 & req1) : (lock0 & req0);

    // State register; last_grant resets to the loader so the CPU takes the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= REQ_LDR;
            win_q   <= REQ_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next state: pick a requester (locked winner first) and latch its command.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ld      = 1'b0;
        ld_id   = pick_winner;
        case (state_q)
            IDLE: begin
                ld = pick_valid;
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                if (keep) begin
                    ld    = 1'b1;
                    ld_id = win_q;
                end else if (pick_valid) begin
                    ld = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (ld) begin
            state_d = ACCESS;
            win_d   = ld_id;
            last_d  = ld_id;
            we_d    = (ld_id == REQ_LDR) ? we1    : we0;
            addr_d  = (ld_id == REQ_LDR) ? addr1  : addr0;
            wdata_d = (ld_id == REQ_LDR) ? wdata1 : wdata0;
        end
    end

    // Outputs decode from state only, so reset clears them (and aborts a write) at once.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        rdata     = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                gnt0      = (win_q == REQ_CPU);
                gnt1      = (win_q == REQ_LDR);
            end
            RESP: begin
                done0 = (win_q == REQ_CPU);
                done1 = (win_q == REQ_LDR);
                rdata = mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against an
// access-schedule reference model and a reference memory.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       rq [2];
    logic       wea[2];
    logic       lk [2];
    logic [7:0] ad [2];
    logic [7:0] wd [2];
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1, mem_en, mem_we;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;

    assign req0 = rq[0];  assign req1 = rq[1];
    assign we0 = wea[0];  assign we1 = wea[1];
    assign lock0 = lk[0]; assign lock1 = lk[1];
    assign addr0 = ad[0]; assign addr1 = ad[1];
    assign wdata0 = wd[0]; assign wdata1 = wd[1];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Environment memory with synchronous read.
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    // Reference model as an access schedule: g_w is who owns the command
    // cycle now, d_w who owns the response cycle now (-1 = nobody).
    int         g_w = -1, d_w = -1, last = 1;
    logic       g_we, d_we;
    logic [7:0] g_addr, g_wd, d_rdata;

    task automatic model_edge;
        int w;
        if (!reset) begin
            g_w = -1; d_w = -1; last = 1;
            return;
        end
        if (g_w >= 0) begin
            d_w = g_w; d_we = g_we; d_rdata = ref_mem[g_addr];
            if (g_we) ref_mem[g_addr] = g_wd;
            g_w = -1;
        end else begin
            w = -1;
            if (d_w >= 0 && rq[d_w] && lk[d_w]) w = d_w;
            else if (rq[0] && rq[1])            w = 1 - last;
            else if (rq[0])                     w = 0;
            else if (rq[1])                     w = 1;
            d_w = -1;
            if (w >= 0) begin
                g_w = w; last = w;
                g_we = wea[w]; g_addr = ad[w]; g_wd = wd[w];
            end
        end
    endtask

    task automatic check_cycle;
        chk("gnt0", gnt0, g_w == 0);
        chk("gnt1", gnt1, g_w == 1);
        chk("mem_en", mem_en, g_w >= 0);
        chk("done0", done0, d_w == 0);
        chk("done1", done1, d_w == 1);
        chk("gnt_excl", gnt0 & gnt1, 0);
        chk("done_excl", done0 & done1, 0);
        if (g_w >= 0) begin
            chk("mem_we", mem_we, g_we);
            chk("mem_addr", mem_addr, g_addr);
            if (g_we) chk("mem_wdata", mem_wdata, g_wd);
        end else if (d_w < 0) begin
            chk("idle_we", mem_we, 0);
            chk("idle_addr", mem_addr, 0);
            chk("idle_rdata", rdata, 0);
        end
        if (d_w >= 0 && !d_we) chk("rdata", rdata, d_rdata);
    endtask

    task automatic cycle;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic apply_reset;
        reset = 1'b0;
        #1;
        chk("rst_gnt", {gnt1, gnt0, done1, done0}, 0);
        chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
        chk("rst_rdata", rdata, 0);
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    logic pend[2];

    task automatic drive_rand;
        for (int i = 0; i < 2; i++) begin
            if (pend[i] && ((i == 0) ? gnt0 : gnt1)) pend[i] = 1'b0;
            if (pend[i]) begin
                if ($urandom_range(0, 19) == 0) begin
                    pend[i] = 1'b0; rq[i] = 1'b0;
                end
            end else if ($urandom_range(0, 9) < 4) begin
                pend[i] = 1'b1; rq[i] = 1'b1;
                wea[i] = 1'($urandom);
                ad[i]  = 8'($urandom_range(0, 15));
                wd[i]  = 8'($urandom);
                lk[i]  = ($urandom_range(0, 2) == 0);
            end else begin
                rq[i] = 1'b0;
                lk[i] = 1'($urandom);
            end
        end
    endtask

    int order[$];
    int ndiff;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom); ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 2; i++) begin
            rq[i] = 0; wea[i] = 0; lk[i] = 0; ad[i] = 0; wd[i] = 0; pend[i] = 0;
        end
        reset = 1'b0;
        @(negedge clk);
        apply_reset();

        // Single CPU read.
        mem[8'h12] = 8'hA5; ref_mem[8'h12] = 8'hA5;
        rq[0] = 1; wea[0] = 0; ad[0] = 8'h12;
        cycle();
        chk("t1_gnt0", gnt0, 1);
        chk("t1_addr", mem_addr, 8'h12);
        rq[0] = 0;
        cycle();
        chk("t1_done0", done0, 1);
        chk("t1_rdata", rdata, 8'hA5);
        cycle();

        // Contended reads after reset alternate starting with the CPU.
        apply_reset();
        rq[0] = 1; rq[1] = 1; wea[0] = 0; wea[1] = 0; ad[0] = 8'h01; ad[1] = 8'h02;
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (gnt0) order.push_back(0);
            if (gnt1) order.push_back(1);
        end
        chk("t2_count", order.size(), 4);
        for (int i = 0; i < order.size() && i < 4; i++) chk("t2_order", order[i], i % 2);
        rq[0] = 0; rq[1] = 0;
        cycle(); cycle();

        // Locked loader burst holds off a waiting CPU.
        apply_reset();
        rq[1] = 1; wea[1] = 1; ad[1] = 8'h40; wd[1] = 8'h01; lk[1] = 1;
        cycle();
        chk("t3_g1a", gnt1, 1);
        rq[0] = 1; wea[0] = 0; ad[0] = 8'h20; ad[1] = 8'h41; wd[1] = 8'h02;
        cycle(); cycle();
        chk("t3_g1b", gnt1, 1);
        chk("t3_addrb", mem_addr, 8'h41);
        ad[1] = 8'h42; wd[1] = 8'h03;
        cycle(); cycle();
        chk("t3_g1c", gnt1, 1);
        chk("t3_addrc", mem_addr, 8'h42);
        rq[1] = 0; lk[1] = 0;
        cycle(); cycle();
        chk("t3_g0", gnt0, 1);
        rq[0] = 0;
        cycle(); cycle();
        chk("t3_m40", mem[8'h40], 8'h01);
        chk("t3_m41", mem[8'h41], 8'h02);
        chk("t3_m42", mem[8'h42], 8'h03);

        // A CPU request pulsed only during the loader's access is never served.
        rq[1] = 1; wea[1] = 0; ad[1] = 8'h07;
        cycle();
        chk("t4_g1", gnt1, 1);
        rq[1] = 0; rq[0] = 1;
        cycle();
        rq[0] = 0;
        cycle();
        chk("t4_no_g0", gnt0, 0);
        chk("t4_idle", mem_en, 0);
        cycle();
        chk("t4_no_g0b", gnt0, 0);

        // Reset during a write command aborts it.
        mem[8'h05] = 8'h3C; ref_mem[8'h05] = 8'h3C;
        rq[0] = 1; wea[0] = 1; ad[0] = 8'h05; wd[0] = 8'h77;
        cycle();
        chk("t5_we_pre", mem_we, 1);
        rq[0] = 0;
        #1 reset = 1'b0;
        #1;
        chk("t5_we_drop", mem_we, 0);
        chk("t5_en_drop", mem_en, 0);
        cycle();
        chk("t5_no_done", done0, 0);
        reset = 1'b1;
        cycle();
        chk("t5_no_done2", done0, 0);
        chk("t5_mem", mem[8'h05], 8'h3C);
        rq[0] = 1; rq[1] = 1; wea[0] = 0; wea[1] = 0;
        cycle();
        chk("t5_tie", gnt0, 1);
        rq[0] = 0; rq[1] = 0;
        cycle(); cycle();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            cycle();
            drive_rand();
        end
        rq[0] = 0; rq[1] = 0;
        repeat (4) cycle();
        ndiff = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) ndiff++;
        chk("mem_image", ndiff, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
